// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: shared types and constants for the Zbb count datapath.
// Contents:
//   cnt_op_e - count operation select (CPOP, CTZ, CLZ; 2'b11 is reserved)
//   CNT_W    - width of a raw population count (0..32 needs 6 bits)
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        CNT_CPOP = 2'b00,
        CNT_CTZ  = 2'b01,
        CNT_CLZ  = 2'b10
    } cnt_op_e;

    localparam int CNT_W = 6;

endpackage

// File: rtl/cv32e40x_alu_b_cnt_prep.sv
// cv32e40x_alu_b_cnt_prep: turns a count op and operand into a mask whose popcount is the answer.
// Ports:
//   op_i      in  [1:0]  cnt_op_e encoding, 2'b11 reserved
//   operand_i in  [31:0] source operand
//   mask_o    out [31:0] mask to be population-counted
module cv32e40x_alu_b_cnt_prep
    import cv32e40x_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_i,
    output logic [31:0] mask_o
);

    logic [31:0] rev;
    logic [31:0] x;

    always_comb begin
        rev = '0;
        for (int i = 0; i < 32; i++) rev[i] = operand_i[31-i];
    end

    // CLZ is CTZ of the bit-reversed operand; ~x & (x-1) keeps only the trailing zeros
    assign x      = (op_i == CNT_CLZ) ? rev : operand_i;
    assign mask_o = (op_i == CNT_CPOP) ? operand_i :
                    (op_i == CNT_CTZ || op_i == CNT_CLZ) ? (~x & (x - 32'd1)) : '0;

endmodule

// File: rtl/cv32e40x_alu_b_cpop.sv
// cv32e40x_alu_b_cpop: 32-bit population count.
// Ports:
//   in_i     in  [31:0]      value to count
//   result_o out [CNT_W-1:0] number of set bits, 0..32
module cv32e40x_alu_b_cpop
    import cv32e40x_pkg::*;
(
    input  logic [31:0]      in_i,
    output logic [CNT_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        for (int i = 0; i < 32; i++) result_o = result_o + {{(CNT_W-1){1'b0}}, in_i[i]};
    end

endmodule

// File: rtl/cv32e40x_alu_b_cnt_pipe.sv
// cv32e40x_alu_b_cnt_pipe: pipelined CPOP/CTZ/CLZ unit with valid/ready on both sides.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   valid_i    request valid          ready_o   request can be accepted
//   op_i       cnt_op_e (11 reserved) operand_i rs1
//   kill_i     flush all in-flight requests, drops a same-cycle request
//   valid_o    result valid           ready_i   consumer accepts result
//   result_o   zero-extended count    busy_o    any stage holds a valid entry
//   zero_o     operand was zero (only with CV32E40X_ALU_B_CNT_ZERO_FLAG_EN)
// REG_OPERAND=1 registers the mask before counting (latency 2); 0 bypasses that stage (latency 1).
module cv32e40x_alu_b_cnt_pipe
    import cv32e40x_pkg::*;
#(
    parameter int REG_OPERAND = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        busy_o
`ifdef CV32E40X_ALU_B_CNT_ZERO_FLAG_EN
    ,
    output logic        zero_o
`endif
);

    logic [31:0]      mask;
    logic             st_valid;
    logic [31:0]      st_mask;
    logic             s1_busy;
    logic             s2_valid;
    logic             s2_ready;
    logic [31:0]      s2_result;
    logic [CNT_W-1:0] cnt;
`ifdef CV32E40X_ALU_B_CNT_ZERO_FLAG_EN
    logic             st_zero;
    logic             s2_zero;
`endif

    cv32e40x_alu_b_cnt_prep u_prep (
        .op_i      (op_i),
        .operand_i (operand_i),
        .mask_o    (mask)
    );

    assign s2_ready = !s2_valid | ready_i;

    generate
        if (REG_OPERAND != 0) begin : g_s1
            logic        s1_valid;
            logic [31:0] s1_mask;
            logic        s1_ready;
            assign s1_ready = !s1_valid | s2_ready;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_mask  <= '0;
                end else if (kill_i) begin
                    s1_valid <= 1'b0;
                end else if (s1_ready) begin
                    s1_valid <= valid_i;
                    if (valid_i) s1_mask <= mask;
                end
            end
`ifdef CV32E40X_ALU_B_CNT_ZERO_FLAG_EN
            logic s1_zero;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) s1_zero <= 1'b0;
                else if (!kill_i && s1_ready && valid_i) s1_zero <= (operand_i == '0);
            end
            assign st_zero = s1_zero;
`endif
            assign ready_o  = s1_ready;
            assign st_valid = s1_valid;
            assign st_mask  = s1_mask;
            assign s1_busy  = s1_valid;
        end else begin : g_bypass
            assign ready_o  = s2_ready;
            assign st_valid = valid_i;
            assign st_mask  = mask;
            assign s1_busy  = 1'b0;
`ifdef CV32E40X_ALU_B_CNT_ZERO_FLAG_EN
            assign st_zero  = (operand_i == '0);
`endif
        end
    endgenerate

    cv32e40x_alu_b_cpop u_cpop (
        .in_i     (st_mask),
        .result_o (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else if (kill_i) begin
            s2_valid  <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= st_valid;
            if (st_valid) s2_result <= {{(32-CNT_W){1'b0}}, cnt};
        end
    end

`ifdef CV32E40X_ALU_B_CNT_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s2_zero <= 1'b0;
        else if (!kill_i && s2_ready && st_valid) s2_zero <= st_zero;
    end
    assign zero_o = s2_zero;
`endif

    assign valid_o  = s2_valid;
    assign result_o = s2_result;
    assign busy_o   = s1_busy | s2_valid;

endmodule

// File: tb/tb_cv32e40x_alu_b_cnt_pipe.sv
// tb_cv32e40x_alu_b_cnt_pipe: directed self-checking bench for the count pipeline (REG_OPERAND=1).
module tb_cv32e40x_alu_b_cnt_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] operand_i = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic        busy_o;
`ifdef CV32E40X_ALU_B_CNT_ZERO_FLAG_EN
    logic        zero_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40x_alu_b_cnt_pipe #(.REG_OPERAND(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .operand_i (operand_i),
        .kill_i    (kill_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .busy_o    (busy_o)
`ifdef CV32E40X_ALU_B_CNT_ZERO_FLAG_EN
        ,
        .zero_o    (zero_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid_o=%b busy_o=%b result_o=%h expected 0 0 00000000", valid_o, busy_o, result_o);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_o=%b expected 1", ready_o);
        end
    endtask

    task automatic test_latency();
        ready_i = 1'b1;
        valid_i = 1'b1; op_i = 2'b00; operand_i = 32'hF0F0_0001;
        step();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL latency_n1: valid_o=%b busy_o=%b expected 0 1", valid_o, busy_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'h9) begin
            errors++;
            $display("FAIL latency_n2: valid_o=%b result_o=%h expected 1 00000009", valid_o, result_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_drain: valid_o=%b busy_o=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_ops();
        logic [1:0]  ops  [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        logic [31:0] xs   [8] = '{32'h0000_0100, 32'h0001_0000, 32'h0, 32'h0, 32'hDEAD_BEEF,
                                  32'h0, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exps [8] = '{32'd8, 32'd15, 32'd32, 32'd32, 32'd0, 32'd0, 32'd31, 32'd0};
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1; op_i = ops[i]; operand_i = xs[i];
            step();
            valid_i = 1'b0;
            step();
            checks++;
            if (valid_o !== 1'b1 || result_o !== exps[i]) begin
                errors++;
                $display("FAIL op_%0d(op=%b x=%h): valid_o=%b result_o=%h expected 1 %h",
                         i, ops[i], xs[i], valid_o, result_o, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs   [3] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        logic [31:0] exps [3] = '{32'd32, 32'd0, 32'd1};
        ready_i = 1'b1;
        op_i = 2'b00;
        for (int i = 0; i < 5; i++) begin
            valid_i = (i < 3);
            if (i < 3) operand_i = xs[i];
            checks += (i < 3) ? 1 : 0;
            if (i < 3 && ready_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: ready_o=%b expected 1", i, ready_o);
            end
            step();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (valid_o !== 1'b1 || result_o !== exps[i-1]) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: valid_o=%b result_o=%h expected 1 %h",
                             i - 1, valid_o, result_o, exps[i-1]);
                end
            end
        end
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: valid_o=%b busy_o=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        op_i = 2'b00;
        valid_i = 1'b1; operand_i = 32'h3;
        step();
        operand_i = 32'h7;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_ready: ready_o=%b expected 1", ready_o);
        end
        step();
        operand_i = 32'hF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || result_o !== 32'd2 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: ready_o=%b valid_o=%b result_o=%h busy_o=%b expected 0 1 00000002 1",
                         i, ready_o, valid_o, result_o, busy_o);
            end
            step();
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: ready_o=%b expected 1", ready_o);
        end
        step();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'd3) begin
            errors++;
            $display("FAIL bp_drain_b: valid_o=%b result_o=%h expected 1 00000003", valid_o, result_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'd4) begin
            errors++;
            $display("FAIL bp_drain_c: valid_o=%b result_o=%h expected 1 00000004", valid_o, result_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid_o=%b busy_o=%b expected 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_kill();
        ready_i = 1'b0;
        op_i = 2'b00;
        valid_i = 1'b1; operand_i = 32'h1;
        step();
        operand_i = 32'h3;
        step();
        operand_i = 32'h7;
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_flush: valid_o=%b busy_o=%b expected 0 0", valid_o, busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL kill_no_result_%0d: valid_o=%b result_o=%h expected valid_o 0", i, valid_o, result_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        op_i = 2'b00;
        valid_i = 1'b1; operand_i = 32'hFF;
        step();
        valid_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'd8) begin
            errors++;
            $display("FAIL rstmid_pre: valid_o=%b result_o=%h expected 1 00000008", valid_o, result_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: valid_o=%b busy_o=%b result_o=%h expected 0 0 00000000", valid_o, busy_o, result_o);
        end
        step();
        rst = 1'b0;
        ready_i = 1'b1;
        step();
        valid_i = 1'b1; op_i = 2'b10; operand_i = 32'h1;
        step();
        valid_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'd31) begin
            errors++;
            $display("FAIL rstmid_clz: valid_o=%b result_o=%h expected 1 0000001f", valid_o, result_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
